// File: rtl/gps_doppler_sched.sv
// gps_doppler_sched: epoch-driven Doppler/code frequency ramp scheduler for gps_emulator.
// One shared adder walks the working array; results are published atomically in APPLY.
module gps_doppler_sched #(
    parameter int Nsat = 4,
    parameter int Nepw = 24
) (
    input  logic                   axi_aclk,
    input  logic                   axi_aresetn,
    input  logic                   enable,
    input  logic                   load,
    input  logic                   dv_in,
    input  logic [Nepw-1:0]        epoch_len,
    input  logic [Nsat-1:0][31:0]  dop_base,
    input  logic [Nsat-1:0][31:0]  dop_rate,
    input  logic [Nsat-1:0][31:0]  code_base,
    input  logic [Nsat-1:0][31:0]  code_rate,
    output logic [Nsat-1:0][31:0]  dop_freq,
    output logic [Nsat-1:0][31:0]  code_freq,
    output logic                   epoch_pulse,
    output logic [31:0]            epoch_count,
    output logic                   overrun,
    output logic                   busy
);
    localparam int Nent = 2 * Nsat;
    localparam int IW   = $clog2(Nent);

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_RUN, S_UPDATE, S_APPLY} state_t;

    state_t               r_state, w_next;
    logic [Nepw-1:0]      r_cnt;
    logic [Nepw-1:0]      w_last;
    logic                 w_term;
    logic [IW-1:0]        r_idx;
    logic [31:0]          r_work [Nent];
    logic [31:0]          w_base [Nent];
    logic [31:0]          w_rate [Nent];
    logic [31:0]          w_sum;
    logic [Nsat-1:0][31:0] r_dop, r_code;
    logic                 r_pulse, r_ovr;
    logic [31:0]          r_count;

    always_comb begin
        for (int i = 0; i < Nsat; i++) begin
            w_base[i]        = dop_base[i];
            w_base[Nsat + i] = code_base[i];
            w_rate[i]        = dop_rate[i];
            w_rate[Nsat + i] = code_rate[i];
        end
    end

    // epoch_len of 0 behaves as 1, so every dv_in is terminal
    assign w_last = (epoch_len == '0) ? '0 : epoch_len - Nepw'(1);
    assign w_term = dv_in && (r_cnt == w_last);
    assign w_sum  = r_work[r_idx] + w_rate[r_idx];

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   w_next = load ? S_LOAD : (enable ? S_RUN : S_IDLE);
            S_LOAD:   w_next = enable ? S_RUN : S_IDLE;
            S_RUN:    w_next = !enable ? S_IDLE : (w_term ? S_UPDATE : S_RUN);
            S_UPDATE: w_next = (r_idx == IW'(Nent - 1)) ? S_APPLY : S_UPDATE;
            S_APPLY:  w_next = enable ? S_RUN : S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_dop   <= '0;
            r_code  <= '0;
            r_pulse <= 1'b0;
            r_ovr   <= 1'b0;
            r_count <= '0;
            for (int i = 0; i < Nent; i++) r_work[i] <= '0;
        end else begin
            r_state <= w_next;
            r_pulse <= (r_state == S_APPLY);
            r_idx   <= (r_state == S_UPDATE) ? r_idx + 1'b1 : '0;
            if (r_state == S_IDLE || r_state == S_LOAD || (r_state == S_RUN && !enable))
                r_cnt <= '0;
            else if (dv_in)
                r_cnt <= w_term ? '0 : r_cnt + 1'b1;
            // a boundary arriving while busy is dropped, not queued
            if (w_term && (r_state == S_UPDATE || r_state == S_APPLY))
                r_ovr <= 1'b1;
            if (r_state == S_UPDATE)
                r_work[r_idx] <= w_sum;
            if (r_state == S_LOAD) begin
                for (int i = 0; i < Nent; i++) r_work[i] <= w_base[i];
                r_dop   <= dop_base;
                r_code  <= code_base;
                r_count <= '0;
                r_ovr   <= 1'b0;
            end
            if (r_state == S_APPLY) begin
                for (int i = 0; i < Nsat; i++) begin
                    r_dop[i]  <= r_work[i];
                    r_code[i] <= r_work[Nsat + i];
                end
                r_count <= r_count + 1'b1;
            end
        end
    end

    assign dop_freq    = r_dop;
    assign code_freq   = r_code;
    assign epoch_pulse = r_pulse;
    assign epoch_count = r_count;
    assign overrun     = r_ovr;
    assign busy        = (r_state == S_UPDATE) || (r_state == S_APPLY);
endmodule

// File: tb/tb_gps_doppler_sched.sv
// tb_gps_doppler_sched: directed stimulus against an epoch-level model of the scheduler.
// The model publishes old+rate a fixed 9 edges after each accepted epoch boundary.
module tb_gps_doppler_sched;
    localparam int NS = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic ena = 1'b0, ld = 1'b0, dv = 1'b0;
    logic [23:0] elen = 24'd16;
    logic [NS-1:0][31:0] dop_base = '0, dop_rate = '0, code_base = '0, code_rate = '0;
    logic [NS-1:0][31:0] dop_freq, code_freq;
    logic        epoch_pulse, overrun, busy;
    logic [31:0] epoch_count;

    int n_tests = 0, n_fail = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    gps_doppler_sched #(.Nsat(NS), .Nepw(24)) dut (
        .axi_aclk(clk), .axi_aresetn(rst_n), .enable(ena), .load(ld), .dv_in(dv),
        .epoch_len(elen), .dop_base(dop_base), .dop_rate(dop_rate),
        .code_base(code_base), .code_rate(code_rate), .dop_freq(dop_freq),
        .code_freq(code_freq), .epoch_pulse(epoch_pulse), .epoch_count(epoch_count),
        .overrun(overrun), .busy(busy)
    );

    logic [31:0] m_dop [NS];
    logic [31:0] m_code [NS];
    logic [31:0] m_cnt;
    bit m_pulse, m_ovr, m_run, m_loading;
    int m_samples, m_pend;

    always @(posedge clk or negedge rst_n) begin
        int len;
        if (!rst_n) begin
            for (int i = 0; i < NS; i++) begin m_dop[i] = '0; m_code[i] = '0; end
            m_cnt = '0; m_pulse = 0; m_ovr = 0; m_run = 0; m_loading = 0;
            m_samples = 0; m_pend = 0;
        end else begin
            len = (elen == 0) ? 1 : int'(elen);
            m_pulse = 0;
            if (m_pend > 0) begin
                if (dv) begin
                    if (m_samples == len - 1) begin m_samples = 0; m_ovr = 1; end
                    else m_samples++;
                end
                m_pend--;
                if (m_pend == 0) begin
                    for (int i = 0; i < NS; i++) begin
                        m_dop[i]  = m_dop[i] + dop_rate[i];
                        m_code[i] = m_code[i] + code_rate[i];
                    end
                    m_pulse = 1; m_cnt = m_cnt + 1; m_run = ena;
                end
            end else if (m_loading) begin
                for (int i = 0; i < NS; i++) begin m_dop[i] = dop_base[i]; m_code[i] = code_base[i]; end
                m_cnt = 0; m_ovr = 0; m_samples = 0; m_loading = 0; m_run = ena;
            end else if (m_run) begin
                if (!ena) begin m_run = 0; m_samples = 0; end
                else if (dv) begin
                    if (m_samples == len - 1) begin m_samples = 0; m_pend = 2 * NS + 1; end
                    else m_samples++;
                end
            end else begin
                m_samples = 0;
                if (ld) m_loading = 1;
                else if (ena) m_run = 1;
            end
        end
    end

    task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            for (int i = 0; i < NS; i++) begin
                check($sformatf("dop_freq[%0d]", i), dop_freq[i], m_dop[i]);
                check($sformatf("code_freq[%0d]", i), code_freq[i], m_code[i]);
            end
            check("epoch_pulse", 32'(epoch_pulse), 32'(m_pulse));
            check("epoch_count", epoch_count, m_cnt);
            check("overrun", 32'(overrun), 32'(m_ovr));
            check("busy", 32'(busy), 32'(m_pend > 0));
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic dv_pulses(int n);
        repeat (n) begin dv = 1; tick(); dv = 0; repeat (3) tick(); end
    endtask

    task automatic wait_pub(string nm);
        int k = 0;
        while (!epoch_pulse && k < 40) begin tick(); k++; end
        check({nm, " pulse seen"}, 32'(epoch_pulse), 32'd1);
    endtask

    initial begin
        int k;
        repeat (3) tick();
        rst_n = 1;
        tick();
        chk_en = 1;
        check("rst busy", 32'(busy), 0);
        check("rst count", epoch_count, 0);
        check("rst dop2", dop_freq[2], 0);

        dop_base[2] = 32'h0001_0000;
        ld = 1; tick(); ld = 0; tick();
        check("load dop2", dop_freq[2], 32'h0001_0000);
        check("load pulse", 32'(epoch_pulse), 0);
        check("load count", epoch_count, 0);

        dop_base[0] = 100; dop_rate[0] = -3; code_base[1] = 1000; code_rate[1] = 5;
        dop_base[3] = 32'hFFFF_FFFE; dop_rate[3] = 3; elen = 16;
        ld = 1; ena = 1; tick(); ld = 0; tick();
        dv_pulses(15);
        dv = 1; tick(); dv = 0;
        k = 0;
        while (dop_freq[0] == 100 && k < 30) begin tick(); k++; end
        check("latency", 32'(k), 9);
        check("ep1 dop0", dop_freq[0], 97);
        check("ep1 code1", code_freq[1], 1005);
        check("ep1 dop3 wrap", dop_freq[3], 1);
        check("ep1 pulse", 32'(epoch_pulse), 1);
        check("ep1 count", epoch_count, 1);
        tick();
        check("pulse width", 32'(epoch_pulse), 0);
        repeat (2) begin dv_pulses(16); wait_pub("ramp"); end
        check("ep3 dop0", dop_freq[0], 91);
        check("ep3 code1", code_freq[1], 1015);
        check("ep3 dop3", dop_freq[3], 7);
        check("ep3 count", epoch_count, 3);

        dv_pulses(15);
        dv = 1; tick(); dv = 0; tick(); tick();
        check("drop busy", 32'(busy), 1);
        ena = 0;
        wait_pub("drop");
        check("drop dop0", dop_freq[0], 88);
        check("drop count", epoch_count, 4);
        dv_pulses(12);
        check("drop idle busy", 32'(busy), 0);
        check("drop frozen count", epoch_count, 4);
        check("drop frozen dop0", dop_freq[0], 88);

        elen = 0; ld = 1; ena = 1; tick(); ld = 0; tick();
        dv = 1; tick(); dv = 0;
        wait_pub("len0");
        check("len0 dop0", dop_freq[0], 97);
        check("len0 count", epoch_count, 1);

        ena = 0; tick();
        elen = 4; ld = 1; ena = 1; tick(); ld = 0; dv = 1; tick();
        repeat (60) tick();
        check("ovr set", 32'(overrun), 1);
        check("ovr slow epochs", 32'(epoch_count < 15), 1);
        dv = 0; ena = 0;
        k = 0;
        while (busy && k < 20) begin tick(); k++; end
        tick();
        check("ovr sticky", 32'(overrun), 1);
        ld = 1; tick(); ld = 0; tick();
        check("ovr cleared", 32'(overrun), 0);
        check("ovr count cleared", epoch_count, 0);

        elen = 16; ena = 1; tick();
        dv_pulses(15);
        dv = 1; tick(); dv = 0; tick(); tick();
        check("pre-reset busy", 32'(busy), 1);
        ena = 0;
        #2 rst_n = 0;
        #1;
        check("async busy", 32'(busy), 0);
        check("async dop0", dop_freq[0], 0);
        check("async code1", code_freq[1], 0);
        check("async count", epoch_count, 0);
        check("async pulse", 32'(epoch_pulse), 0);
        tick();
        rst_n = 1;
        tick(); tick();
        check("post-reset busy", 32'(busy), 0);
        check("post-reset dop0", dop_freq[0], 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/gps_doppler_sched.md
Name: gps_doppler_sched

Overview:
- Per-satellite frequency scheduler that drives the dop_freq and code_freq inputs of gps_emulator.
- Software loads a base frequency and a signed per-epoch rate for every satellite's Doppler and code NCO.
- The block counts sample strobes (the same dv heartbeat fed to the emulator). At each epoch boundary it ramps all frequencies using one shared adder, walked sequentially across the satellites.
- New values are published atomically, so the emulator never sees a partially updated satellite set.

Parameters:
- Nsat, 4, number of satellite channels.
- Nepw, 24, width of epoch_len and of the internal sample counter.

Ports:
- axi_aclk  input  1  clock.
- axi_aresetn  input  1  asynchronous active-low reset.
- enable  input  1  level; 1 = run epochs.
- load  input  1  single-cycle pulse; copy base values into working and output registers.
- dv_in  input  1  sample strobe, one cycle wide.
- epoch_len  input  Nepw  samples per epoch; 0 is treated as 1.
- dop_base  input  32 x Nsat  initial Doppler phase increment.
- dop_rate  input  32 x Nsat  signed (two's complement) Doppler delta per epoch.
- code_base  input  32 x Nsat  initial code phase increment.
- code_rate  input  32 x Nsat  signed code delta per epoch.
- dop_freq  output  32 x Nsat  published Doppler frequency, to the emulator.
- code_freq  output  32 x Nsat  published code frequency, to the emulator.
- epoch_pulse  output  1  one cycle high when new values are published.
- epoch_count  output  32  epochs published since the last load.
- overrun  output  1  sticky: an epoch boundary was skipped.
- busy  output  1  high in UPDATE or APPLY.

Behaviour:
- Reset: all outputs 0, working registers 0, sample counter 0, state IDLE.
- Working array: 2*Nsat entries.
  - Index i < Nsat is Doppler for satellite i.
  - Index Nsat+i is code for satellite i.
- States: IDLE, LOAD, RUN, UPDATE, APPLY.
- IDLE:
  - Outputs hold; the sample counter is held at 0.
  - load=1 -> LOAD.
  - Otherwise enable=1 -> RUN.
  - load wins if load and enable are both high.
- LOAD (1 cycle):
  - working and outputs <= base values.
  - epoch_count <= 0, overrun <= 0, sample counter <= 0.
  - Next state is RUN if enable=1, else IDLE.
  - No epoch_pulse is generated.
- load outside IDLE is ignored.
- Sample counter:
  - Increments on dv_in in RUN, UPDATE and APPLY.
  - Terminal when dv_in=1 and count = max(epoch_len,1)-1; the counter then wraps to 0.
- Terminal count in RUN -> UPDATE with index 0.
- Terminal count while in UPDATE or APPLY:
  - overrun <= 1.
  - That epoch's update is skipped; it is not queued.
  - The counter still wraps.
- UPDATE, one entry per cycle:
  - working[idx] <= working[idx] + rate[idx], modulo 2^32 (wraps, no saturation).
  - idx runs 0 to 2*Nsat-1, then the state goes to APPLY.
  - A single 32-bit adder is shared across all entries.
- APPLY (1 cycle):
  - dop_freq/code_freq <= working.
  - epoch_pulse = 1 in the following cycle, coincident with the first cycle the new outputs are visible.
  - epoch_count increments, wrapping at 2^32.
  - Next state is RUN if enable=1, else IDLE.
- Latency: the edge sampling the terminal dv_in is E0. Outputs change on edge E(2*Nsat+1) and epoch_pulse is high for the cycle after it.
- With Nsat=4, the minimum overrun-free epoch is 10 samples when dv_in is high every cycle.
- enable deasserted mid-UPDATE/APPLY: the update completes and is published, then the state goes to IDLE.
- enable deasserted in RUN: go to IDLE and clear the sample counter. Published outputs hold.
- Rates are sampled live during UPDATE. Software changes them only while in IDLE.
- busy is high in UPDATE and APPLY.
- Asynchronous reset mid-operation returns every register to its reset value immediately.

Test Plan:
- Reset check: assert axi_aresetn=0 mid-UPDATE -> all outputs, including busy, read 0 immediately; after release the state is IDLE.
- Load only: dop_base[2]=32'h0001_0000, load pulse with enable=0 -> dop_freq[2]=32'h0001_0000 the next cycle; epoch_pulse stays 0; epoch_count=0.
- Ramp, first epoch: dop_base[0]=100, dop_rate[0]=-3, code_base[1]=1000, code_rate[1]=5, epoch_len=16, dv_in every 4th cycle, enable=1.
  - After 16 dv_in: dop_freq[0]=97, code_freq[1]=1005.
  - Outputs change exactly 9 edges after the terminal dv_in.
  - epoch_pulse is high one cycle; epoch_count=1.
- Ramp, third epoch (same setup): dop_freq[0]=91, code_freq[1]=1015, epoch_count=3.
- Wrap: dop_base[3]=32'hFFFF_FFFE, dop_rate[3]=3 -> after one epoch dop_freq[3]=1.
- Overrun: epoch_len=4, dv_in every cycle -> second terminal count lands in UPDATE; overrun=1 and stays 1; epoch_count advances less than once per 4 samples; the next load clears overrun.
- enable drop: deassert enable during UPDATE -> APPLY still publishes with a single epoch_pulse, then busy=0 and the block stays idle with outputs frozen.
